// File: rtl/task_fifo_sched_pkg.sv
// Shared task word layout and helpers for the TaskFIFO front/back-end controller.
// The task word width follows the default PIFO tree configuration.
package task_pkg;

    localparam int PTW           = 16;
    localparam int MTW           = 16;
    localparam int TREE_NUM      = 4;
    localparam int TREE_NUM_BITS = $clog2(TREE_NUM);
    localparam int TW            = PTW + MTW + 2*TREE_NUM_BITS + 2;

    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_PUSH    = 2'b01,
        OP_POP     = 2'b10,
        OP_PUSHPOP = 2'b11
    } op_t;

    typedef struct packed {
        op_t                      op;
        logic [TREE_NUM_BITS-1:0] src_tree;
        logic [TREE_NUM_BITS-1:0] dst_tree;
        logic [MTW-1:0]           meta;
        logic [PTW-1:0]           payload;
    } task_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/task_fifo_sched_rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer, pointer moves past the winner.
// The pointer only advances when a grant is actually issued.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    logic [PW-1:0] ptr;
    logic          found;
    int            scan;

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan      = 0;
        for (int k = 0; k < N; k++) begin
            scan = int'(ptr) + k;
            if (scan >= N) scan = scan - N;
            if (!found && req[scan]) begin
                found     = 1'b1;
                grant_idx = PW'(scan);
            end
        end
        grant = (en && found) ? (N'(1) << grant_idx) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (en && found)
            ptr <= (grant_idx == PW'(N-1)) ? '0 : grant_idx + PW'(1);
    end

endmodule

// File: rtl/task_fifo_sched.sv
// TaskFIFO controller: round-robin write arbitration, credit-based reads against the
// FIFO's one-cycle read latency, and a 2-deep output buffer feeding valid/ready.
module task_fifo_sched #(
    parameter  int PTW      = 16,
    parameter  int MTW      = 16,
    parameter  int TREE_NUM = 4,
    parameter  int BUF_SIZE = 8,
    localparam int TNB      = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1,
    localparam int TW       = PTW + MTW + 2*$clog2(TREE_NUM) + 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TREE_NUM-1:0]    req_valid,
    input  logic [TREE_NUM*TW-1:0] req_data,
    output logic [TREE_NUM-1:0]    req_ready,
    output logic                   fifo_wr_en,
    output logic [TW-1:0]          fifo_buf_in,
    output logic                   fifo_rd_en,
    input  logic [TW-1:0]          fifo_buf_out,
    input  logic                   fifo_empty,
    input  logic                   fifo_full,
    output logic                   task_valid,
    output logic [TW-1:0]          task_data,
    input  logic                   task_ready,
    output logic [15:0]            tasks_in
);
    import task_pkg::*;

    if (BUF_SIZE < 1) begin : g_bad_buf_size
        $error("task_fifo_sched: BUF_SIZE must be at least 1");
    end

    logic [TREE_NUM-1:0] grant;
    logic [TNB-1:0]      grant_idx;

    // Gating with rst keeps every combinational output low while reset is held.
    rr_arbiter #(.N(TREE_NUM)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .en        (!fifo_full && !rst),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready   = grant;
    assign fifo_wr_en  = |grant;
    assign fifo_buf_in = fifo_wr_en ? req_data[grant_idx*TW +: TW] : '0;

    logic [1:0]    occ;
    logic          inflight;
    logic [TW-1:0] buf0, buf1;
    logic [2:0]    avail, after_pop;
    logic          pop;
    logic [TW-1:0] head;
    logic [TW-1:0] nxt_buf0, nxt_buf1;

    // Data still in flight from the FIFO is visible downstream straight away, so the
    // head bypasses the buffer when it is empty; capture happens on the same edge.
    always_comb begin
        avail      = {1'b0, occ} + {2'b00, inflight};
        task_valid = (avail != 3'd0);
        head       = (occ != 2'd0) ? buf0 : fifo_buf_out;
        task_data  = task_valid ? head : '0;
        pop        = task_valid && task_ready;
        after_pop  = avail - {2'b00, pop};
        fifo_rd_en = !rst && !fifo_empty && (after_pop < 3'd2);
        nxt_buf0   = buf0;
        nxt_buf1   = buf1;
        if (pop)
            nxt_buf0 = (occ == 2'd2) ? buf1 : fifo_buf_out;
        else if (inflight) begin
            if (occ == 2'd0) nxt_buf0 = fifo_buf_out;
            else             nxt_buf1 = fifo_buf_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= '0;
            inflight <= 1'b0;
            buf0     <= '0;
            buf1     <= '0;
            tasks_in <= '0;
        end else begin
            occ      <= after_pop[1:0];
            inflight <= fifo_rd_en;
            buf0     <= nxt_buf0;
            buf1     <= nxt_buf1;
            if (fifo_wr_en) tasks_in <= sat_inc16(tasks_in);
        end
    end

endmodule
